sm_dmem_arbiter: RTL and testbench

Two-master arbiter that shares the single data-memory port between the CPU data port (master 0) and a second requester such as a DMA or debug loader (master 1). It sits between the masters and a synchronous-read data memory with one-cycle read latency. It grants one master per cycle, steers its address, write enable and write data to memory, and routes read data back to the issuing master. It supports a bounded bus lock for short multi-beat transfers.

---
 rtl/sm_dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_sm_dmem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sm_dmem_arbiter.sv
// Two-master arbiter sharing one synchronous-read data-memory port, with bounded bus lock.
// Define SM_ARB_RR_EN for round-robin tie-break; otherwise master 0 has fixed priority.
module sm_dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] s_addr,
  output logic          s_we,
  output logic          s_re,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata
);

  localparam int            CW      = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          rpend_q, rpend_d;
  logic          rown_q, rown_d;

  logic owner;
  logic in_lock;
  logic locked;
  logic expired;
  logic gnt_any;
  logic gnt_idx;
  logic sel_m1;
  logic sel_we;
  logic sel_lock;

  // Grant selection: a live lock pins ownership, otherwise arbitrate between requesters.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gnt_any = 1'b0;
    gnt_idx = 1'b0;
    owner   = (state_q == LOCK1);
    in_lock = (state_q != IDLE);
    locked  = in_lock && (owner ? m1_lock : m0_lock) && (cnt_q < CNT_MAX);
    expired = in_lock && (cnt_q == CNT_MAX);

    if (locked) begin
      gnt_any = owner ? m1_req : m0_req;
      gnt_idx = owner;
    end else if (m0_req && m1_req) begin
      gnt_any = 1'b1;
`ifdef SM_ARB_RR_EN
      gnt_idx = ~last_q;
`else
      gnt_idx = 1'b0;
`endif
      // An owner that ran out its lock yields the next contention to the waiting master.
      if (expired) gnt_idx = ~owner;
    end else if (m0_req || m1_req) begin
      gnt_any = 1'b1;
      gnt_idx = m1_req;
    end

    if (rst) gnt_any = 1'b0;
  end

  always_comb begin
    state_d  = IDLE;
    cnt_d    = '0;
    sel_lock = gnt_idx ? m1_lock : m0_lock;
    if (locked) begin
      state_d = state_q;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end else if (gnt_any && sel_lock) begin
      state_d = gnt_idx ? LOCK1 : LOCK0;
      cnt_d   = CW'(1);
    end
  end

  assign sel_m1 = gnt_any & gnt_idx;
  assign sel_we = sel_m1 ? m1_we : m0_we;

  assign m0_gnt  = gnt_any & ~gnt_idx;
  assign m1_gnt  = gnt_any &  gnt_idx;
  assign s_addr  = sel_m1 ? m1_addr  : m0_addr;
  assign s_wdata = sel_m1 ? m1_wdata : m0_wdata;
  assign s_we    = gnt_any &  sel_we;
  assign s_re    = gnt_any & ~sel_we;

  assign last_d  = gnt_any ? gnt_idx : last_q;
  assign rpend_d = s_re;
  assign rown_d  = gnt_any ? gnt_idx : rown_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      rpend_q <= 1'b0;
      rown_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rpend_q <= rpend_d;
      rown_q  <= rown_d;
    end
  end

  // Read data is broadcast; rvalid alone tells each master the beat is theirs.
  assign m0_rvalid = rpend_q & ~rown_q;
  assign m1_rvalid = rpend_q &  rown_q;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

endmodule

// File: tb/tb_sm_dmem_arbiter.sv
// Directed self-checking bench for sm_dmem_arbiter with a one-cycle-latency memory model.
// Expectations follow SM_ARB_RR_EN when it is defined for the build.
module tb_sm_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_LOCK = 8;
  localparam logic [31:0] D10 = 32'hA000_0004;  // preload of word 0x10
  localparam logic [31:0] D20 = 32'hA000_0008;  // preload of word 0x20

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic          s_we, s_re;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_pass   = 0;

  sm_dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_we(s_we), .s_re(s_re), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word-addressed, preloaded during reset, one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else begin
      if (s_we) mem[s_addr[9:2]] <= s_wdata;
      if (s_re) s_rdata <= mem[s_addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic w, prev_w;

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    s_rdata = '0;
    prev_w = 1'b0;

    // Reset holds off every grant and memory strobe.
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h10;
    m1_req = 1'b1; m1_addr = 32'h20;
    #1;
    check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    check("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    check("rst_s_re",   32'(s_re),   32'd0);
    check("rst_s_we",   32'(s_we),   32'd0);
    next_cycle();
    rst = 1'b0;

    // Both masters read every cycle.
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      #1;
`ifdef SM_ARB_RR_EN
      w = (k % 2) == 1;
`else
      w = 1'b0;
`endif
      check($sformatf("cont_m0_gnt_%0d", k), 32'(m0_gnt), 32'(!w));
      check($sformatf("cont_m1_gnt_%0d", k), 32'(m1_gnt), 32'(w));
      check($sformatf("cont_s_addr_%0d", k), s_addr, w ? 32'h20 : 32'h10);
      if (k == 0) begin
        check("cont_m0_rvalid_0", 32'(m0_rvalid), 32'd0);
        check("cont_m1_rvalid_0", 32'(m1_rvalid), 32'd0);
      end else begin
        check($sformatf("cont_m0_rvalid_%0d", k), 32'(m0_rvalid), 32'(!prev_w));
        check($sformatf("cont_m1_rvalid_%0d", k), 32'(m1_rvalid), 32'(prev_w));
        check($sformatf("cont_rdata_%0d", k), prev_w ? m1_rdata : m0_rdata, prev_w ? D20 : D10);
      end
      prev_w = w;
    end

    // m0 writes 0x40, m1 reads it back on the next cycle.
    next_cycle();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hDEADBEEF;
    #1;
    check("wr_m0_gnt",  32'(m0_gnt), 32'd1);
    check("wr_s_we",    32'(s_we),   32'd1);
    check("wr_s_re",    32'(s_re),   32'd0);
    check("wr_s_addr",  s_addr,      32'h40);
    check("wr_s_wdata", s_wdata,     32'hDEADBEEF);
    check("wr_prev_rvalid", 32'(prev_w ? m1_rvalid : m0_rvalid), 32'd1);
    check("wr_prev_rdata",  prev_w ? m1_rdata : m0_rdata, prev_w ? D20 : D10);

    next_cycle();
    m0_req = 1'b0; m0_we = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
    #1;
    check("rd_m1_gnt",    32'(m1_gnt),    32'd1);
    check("rd_s_re",      32'(s_re),      32'd1);
    check("wr_no_rvalid", 32'(m0_rvalid), 32'd0);

    next_cycle();
    m1_req = 1'b0; m1_addr = 32'h20;
    m0_addr = 32'h44;
    #1;
    check("rd_m1_rvalid", 32'(m1_rvalid), 32'd1);
    check("rd_m1_rdata",  m1_rdata,       32'hDEADBEEF);
    check("rd_m0_rvalid", 32'(m0_rvalid), 32'd0);
    check("idle_s_re",    32'(s_re),      32'd0);
    check("idle_s_we",    32'(s_we),      32'd0);
    check("idle_s_addr",  s_addr,         32'h44);

    // m1 holds lock for 20 cycles; m0 requests once from cycle 1 until its single grant.
    m0_addr = 32'h10;
    for (int j = 0; j < 20; j++) begin
      next_cycle();
      m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b0;
      m0_req = (j >= 1) && (j <= 8);
      #1;
      check($sformatf("lk1_m0_gnt_%0d", j), 32'(m0_gnt), 32'(j == 8));
      check($sformatf("lk1_m1_gnt_%0d", j), 32'(m1_gnt), 32'(j != 8));
      if (j == 9) begin
        check("lk1_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("lk1_m0_rdata",  m0_rdata,       D10);
      end
    end
    next_cycle();
    m1_req = 1'b0; m1_lock = 1'b0; m0_req = 1'b0;
    #1;
    check("lk1_end_m1_gnt", 32'(m1_gnt), 32'd0);

    // m0 locks past MAX_LOCK while m1 waits: the expired lock yields to m1.
    for (int j = 0; j < 10; j++) begin
      next_cycle();
      m0_req = 1'b1; m0_lock = 1'b1;
      m1_req = (j >= 1) && (j <= 8);
      #1;
      check($sformatf("lk0_m0_gnt_%0d", j), 32'(m0_gnt), 32'(j != 8));
      check($sformatf("lk0_m1_gnt_%0d", j), 32'(m1_gnt), 32'(j == 8));
    end

    // Owner drops lock while m1 waits: m1 wins that same cycle.
    next_cycle();
    m1_req = 1'b1;
    #1;
    check("drop_pre_m0_gnt", 32'(m0_gnt), 32'd1);
    check("drop_pre_m1_gnt", 32'(m1_gnt), 32'd0);
    next_cycle();
    m0_req = 1'b0; m0_lock = 1'b0;
    #1;
    check("drop_m1_gnt", 32'(m1_gnt), 32'd1);
    check("drop_m0_gnt", 32'(m0_gnt), 32'd0);
    next_cycle();
    m1_req = 1'b0;
    #1;
    check("drop_state_idle", 32'(dut.state_q), 32'd0);

    // Reset lands right after a granted m0 read.
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    #1;
    check("rr_m0_gnt", 32'(m0_gnt), 32'd1);
    check("rr_s_re",   32'(s_re),   32'd1);
    next_cycle();
    rst = 1'b1;
    m1_req = 1'b1; m1_addr = 32'h20;
    #1;
    check("rr_rst_m0_gnt", 32'(m0_gnt), 32'd0);
    check("rr_rst_m1_gnt", 32'(m1_gnt), 32'd0);
    check("rr_rst_s_re",   32'(s_re),   32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rr_post_m0_rvalid", 32'(m0_rvalid), 32'd0);
    check("rr_post_m1_rvalid", 32'(m1_rvalid), 32'd0);
    check("rr_post_state",     32'(dut.state_q), 32'd0);
    check("rr_post_m0_gnt",    32'(m0_gnt), 32'd1);
    check("rr_post_m1_gnt",    32'(m1_gnt), 32'd0);
    next_cycle();
    m0_req = 1'b0;
    #1;
    check("rr_next_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check("rr_next_m0_rdata",  m0_rdata,       D10);
    check("rr_next_m1_gnt",    32'(m1_gnt),    32'd1);

    next_cycle();
    m1_req = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
